// File: rtl/exponent_align_pipe.sv
// exponent_align_pipe: two-stage handshaked exponent comparator and
// alignment-shift generator feeding the FMA mantissa alignment shifter.
// Stage 1 compares exp_ab against the zero-extended exp_c and forms the exact
// distance. Stage 2 flags distances beyond max_shift and forms shift_amt.
// Optional feature macro: EXP_ALIGN_SAT_EN clamps shift_amt to max_shift
// whenever shift_sat is set. Without it, shift_amt is the raw distance.
module exponent_align_pipe #(
  parameter int size_exponent = 8,
  parameter int size_mantissa = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [size_exponent:0]   exp_ab,
  input  logic [size_exponent-1:0] exp_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     compare,
  output logic                     equal,
  output logic [size_exponent:0]   exp_max,
  output logic [size_exponent:0]   shift_amt,
  output logic                     shift_sat
);

  localparam int          EW        = size_exponent + 1;
  localparam logic [31:0] MAX_SHIFT = 32'(2 * size_mantissa + 2);
  localparam logic [EW-1:0] MAX_SHIFT_E = EW'(MAX_SHIFT);

  // Stage 1 state
  logic          s1_valid_q,   s1_valid_d;
  logic          s1_compare_q, s1_compare_d;
  logic          s1_equal_q,   s1_equal_d;
  logic [EW-1:0] s1_exp_max_q, s1_exp_max_d;
  logic [EW-1:0] s1_diff_q,    s1_diff_d;

  // Stage 2 state (drives the outputs)
  logic          s2_valid_q,     s2_valid_d;
  logic          s2_compare_q,   s2_compare_d;
  logic          s2_equal_q,     s2_equal_d;
  logic [EW-1:0] s2_exp_max_q,   s2_exp_max_d;
  logic [EW-1:0] s2_shift_amt_q, s2_shift_amt_d;
  logic          s2_shift_sat_q, s2_shift_sat_d;

  logic          s2_can_load;
  logic          s1_can_load;
  logic          accept;
  logic [EW-1:0] exp_c_ext;
  logic          sat_next;

  // Handshake: a stage may load when empty or when its contents move on.
  assign s2_can_load = !s2_valid_q || out_ready;
  assign s1_can_load = !s1_valid_q || s2_can_load;
  assign in_ready    = s1_can_load;
  assign accept      = in_valid && s1_can_load;
  assign exp_c_ext   = {1'b0, exp_c};
  assign sat_next    = 32'(s1_diff_q) > MAX_SHIFT;

  // Next-state for both stages; each stage holds its data unless it loads.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    s1_valid_d     = s1_valid_q;
    s1_compare_d   = s1_compare_q;
    s1_equal_d     = s1_equal_q;
    s1_exp_max_d   = s1_exp_max_q;
    s1_diff_d      = s1_diff_q;
    s2_valid_d     = s2_valid_q;
    s2_compare_d   = s2_compare_q;
    s2_equal_d     = s2_equal_q;
    s2_exp_max_d   = s2_exp_max_q;
    s2_shift_amt_d = s2_shift_amt_q;
    s2_shift_sat_d = s2_shift_sat_q;

    if (s1_can_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_compare_d = exp_c_ext < exp_ab;
        s1_equal_d   = exp_c_ext == exp_ab;
        if (exp_ab >= exp_c_ext) begin
          s1_exp_max_d = exp_ab;
          s1_diff_d    = exp_ab - exp_c_ext;
        end else begin
          s1_exp_max_d = exp_c_ext;
          s1_diff_d    = exp_c_ext - exp_ab;
        end
      end
    end

    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_compare_d   = s1_compare_q;
        s2_equal_d     = s1_equal_q;
        s2_exp_max_d   = s1_exp_max_q;
        s2_shift_sat_d = sat_next;
`ifdef EXP_ALIGN_SAT_EN
        s2_shift_amt_d = sat_next ? MAX_SHIFT_E : s1_diff_q;
`else
        s2_shift_amt_d = s1_diff_q;
`endif
      end
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared too, since the outputs must read 0 after reset.
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_compare_q   <= 1'b0;
      s1_equal_q     <= 1'b0;
      s1_exp_max_q   <= '0;
      s1_diff_q      <= '0;
      s2_valid_q     <= 1'b0;
      s2_compare_q   <= 1'b0;
      s2_equal_q     <= 1'b0;
      s2_exp_max_q   <= '0;
      s2_shift_amt_q <= '0;
      s2_shift_sat_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both stages update from pre-edge values.
      s1_valid_q     <= s1_valid_d;
      s1_compare_q   <= s1_compare_d;
      s1_equal_q     <= s1_equal_d;
      s1_exp_max_q   <= s1_exp_max_d;
      s1_diff_q      <= s1_diff_d;
      s2_valid_q     <= s2_valid_d;
      s2_compare_q   <= s2_compare_d;
      s2_equal_q     <= s2_equal_d;
      s2_exp_max_q   <= s2_exp_max_d;
      s2_shift_amt_q <= s2_shift_amt_d;
      s2_shift_sat_q <= s2_shift_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign compare   = s2_compare_q;
  assign equal     = s2_equal_q;
  assign exp_max   = s2_exp_max_q;
  assign shift_amt = s2_shift_amt_q;
  assign shift_sat = s2_shift_sat_q;

endmodule

// File: tb/tb_exponent_align_pipe.sv
// Directed bench for exponent_align_pipe (size_exponent=8, size_mantissa=24,
// max_shift=50). Expected shift_amt follows EXP_ALIGN_SAT_EN when defined.
module tb_exponent_align_pipe;

`ifdef EXP_ALIGN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] exp_ab;
  logic [7:0] exp_c;
  logic       out_valid;
  logic       out_ready;
  logic       compare;
  logic       equal;
  logic [8:0] exp_max;
  logic [8:0] shift_amt;
  logic       shift_sat;

  int checks = 0;
  int errors = 0;

  exponent_align_pipe #(.size_exponent(8), .size_mantissa(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_ab    (exp_ab),
    .exp_c     (exp_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .compare   (compare),
    .equal     (equal),
    .exp_max   (exp_max),
    .shift_amt (shift_amt),
    .shift_sat (shift_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic cmp, input logic eq,
                           input logic [8:0] mx, input logic [8:0] amt, input logic sat);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".compare"},   32'(compare),   32'(cmp));
    check({tag, ".equal"},     32'(equal),     32'(eq));
    check({tag, ".exp_max"},   32'(exp_max),   32'(mx));
    check({tag, ".shift_amt"}, 32'(shift_amt), 32'(amt));
    check({tag, ".shift_sat"}, 32'(shift_sat), 32'(sat));
  endtask

  // One isolated transaction with out_ready=1: result appears two edges after accept.
  task automatic send_one(input string tag, input logic [8:0] ab, input logic [7:0] c,
                          input logic cmp, input logic eq, input logic [8:0] mx,
                          input logic [8:0] amt, input logic sat);
    in_valid = 1'b1;
    exp_ab   = ab;
    exp_c    = c;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, ".lat1_valid"}, 32'(out_valid), 32'd0);
    step();
    check_out(tag, cmp, eq, mx, amt, sat);
    step();
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    exp_ab    = '0;
    exp_c     = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.exp_max",   32'(exp_max),   32'd0);
    check("rst.shift_amt", 32'(shift_amt), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);

    // Directed single transactions
    send_one("t1", 9'd130, 8'd127, 1'b1, 1'b0, 9'd130, 9'd3, 1'b0);
    send_one("t2", 9'd100, 8'd200, 1'b0, 1'b0, 9'd200, SAT_EN ? 9'd50 : 9'd100, 1'b1);
    send_one("t3", 9'd127, 8'd127, 1'b0, 1'b1, 9'd127, 9'd0, 1'b0);
    send_one("t5", 9'd511, 8'd0,   1'b1, 1'b0, 9'd511, SAT_EN ? 9'd50 : 9'd511, 1'b1);
    send_one("d50", 9'd60, 8'd10,  1'b1, 1'b0, 9'd60,  9'd50, 1'b0);
    send_one("d51", 9'd10, 8'd61,  1'b0, 1'b0, 9'd61,  SAT_EN ? 9'd50 : 9'd51, 1'b1);

    // Stall: A and B fill the pipe, C waits, then all three drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    exp_ab    = 9'd10;
    exp_c     = 8'd5;
    #1;
    check("t4.A_ready", 32'(in_ready), 32'd1);
    step();
    exp_ab = 9'd20;
    exp_c  = 8'd8;
    #1;
    check("t4.B_ready", 32'(in_ready), 32'd1);
    step();
    exp_ab = 9'd30;
    exp_c  = 8'd30;
    #1;
    check("t4.C_blocked", 32'(in_ready), 32'd0);
    check_out("t4.A_held", 1'b1, 1'b0, 9'd10, 9'd5, 1'b0);
    step();
    check("t4.C_still_blocked", 32'(in_ready), 32'd0);
    check_out("t4.A_stable", 1'b1, 1'b0, 9'd10, 9'd5, 1'b0);
    out_ready = 1'b1;
    #1;
    check("t4.ready_comb", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_out("t4.B", 1'b1, 1'b0, 9'd20, 9'd12, 1'b0);
    step();
    check_out("t4.C", 1'b0, 1'b1, 9'd30, 9'd0, 1'b0);
    step();
    check("t4.drained", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight discards both.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    exp_ab    = 9'd40;
    exp_c     = 8'd1;
    step();
    exp_ab = 9'd3;
    exp_c  = 8'd90;
    step();
    in_valid = 1'b0;
    check("t6.full_valid", 32'(out_valid), 32'd1);
    check("t6.full_ready", 32'(in_ready),  32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6.out_valid", 32'(out_valid), 32'd0);
    check("t6.compare",   32'(compare),   32'd0);
    check("t6.equal",     32'(equal),     32'd0);
    check("t6.exp_max",   32'(exp_max),   32'd0);
    check("t6.shift_amt", 32'(shift_amt), 32'd0);
    check("t6.shift_sat", 32'(shift_sat), 32'd0);
    check("t6.in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6.discarded", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
